// File: rtl/rv_mem_pkg.sv
// Shared types for the rv_mem_resp memory responder: FSM states, port ids, wait-counter width.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    localparam int unsigned WAITW = 4;

endpackage

// File: rtl/rv_mem_array.sv
// Single-port synchronous word RAM; read data is registered on the access edge, contents not reset.
module rv_mem_array #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/rv_mem_resp.sv
// Memory responder serving an instruction port and a data port from one single-ported array.
// Optional address checking is enabled with `define RV_MEM_ADDR_CHECK_EN.
module rv_mem_resp
    import rv_mem_pkg::*;
#(
    parameter int unsigned DPWIDTH    = 32,
    parameter int unsigned MEMWORDS   = 1024,
    parameter int unsigned WAITSTATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_req,
    input  logic [DPWIDTH-1:0] imem_addr,
    output logic [DPWIDTH-1:0] imem_rdata,
    output logic               imem_ready,
    input  logic               dmem_req,
    input  logic               dmem_we,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_wdata,
    output logic [DPWIDTH-1:0] dmem_rdata,
    output logic               dmem_ready,
    output logic               err
);

    localparam int unsigned IDXW = $clog2(MEMWORDS);

    state_t             state, state_nxt;
    port_t              grant, grant_c, cur_port_c;
    logic [WAITW-1:0]   cnt;
    logic               lat_we;
    logic [IDXW-1:0]    lat_idx;
    logic [DPWIDTH-1:0] lat_wdata;
    logic               accept_c, enter_resp_c, ram_en_c;
    logic               cur_we_c, cur_err_c;
    logic [IDXW-1:0]    cur_idx_c;
    logic [DPWIDTH-1:0] cur_wdata_c;
    logic [DPWIDTH-1:0] ram_rdata, imem_hold, dmem_hold;
    logic               i_sel, d_sel;

`ifdef RV_MEM_ADDR_CHECK_EN
    logic lat_err, live_err_c;

    function automatic logic addr_bad(input logic [DPWIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (64'(a) >= 64'(MEMWORDS) * 64'd4);
    endfunction

    assign live_err_c = (grant_c == PORT_D) ? addr_bad(dmem_addr) : addr_bad(imem_addr);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[1:0], imem_addr[DPWIDTH-1:IDXW+2],
                                dmem_addr[1:0], dmem_addr[DPWIDTH-1:IDXW+2]};
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (imem_req || dmem_req)
                         state_nxt = (WAITSTATES == 0) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (cnt <= WAITW'(1)) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration and access decode; in IDLE the live request is used so WAITSTATES=0 works
    always_comb begin
        grant_c = grant;
        if (imem_req && dmem_req) grant_c = (grant == PORT_I) ? PORT_D : PORT_I;
        else if (dmem_req)        grant_c = PORT_D;
        else if (imem_req)        grant_c = PORT_I;
        accept_c     = (state == ST_IDLE) && (imem_req || dmem_req);
        enter_resp_c = (state != ST_RESP) && (state_nxt == ST_RESP);
        if (state == ST_IDLE) begin
            cur_port_c  = grant_c;
            cur_we_c    = (grant_c == PORT_D) && dmem_we;
            cur_idx_c   = (grant_c == PORT_D) ? dmem_addr[IDXW+1:2] : imem_addr[IDXW+1:2];
            cur_wdata_c = dmem_wdata;
        end else begin
            cur_port_c  = grant;
            cur_we_c    = lat_we;
            cur_idx_c   = lat_idx;
            cur_wdata_c = lat_wdata;
        end
`ifdef RV_MEM_ADDR_CHECK_EN
        cur_err_c = (state == ST_IDLE) ? live_err_c : lat_err;
`else
        cur_err_c = 1'b0;
`endif
        ram_en_c = enter_resp_c && !cur_err_c;
    end

    // Request latches, wait counter and last-grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            grant     <= PORT_I;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept_c) begin
            cnt       <= WAITW'(WAITSTATES);
            grant     <= grant_c;
            lat_we    <= cur_we_c;
            lat_idx   <= cur_idx_c;
            lat_wdata <= cur_wdata_c;
        end else if (state == ST_BUSY) begin
            cnt <= cnt - WAITW'(1);
        end
    end

`ifdef RV_MEM_ADDR_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          lat_err <= 1'b0;
        else if (accept_c) lat_err <= live_err_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= enter_resp_c && cur_err_c;
    end
`else
    assign err = 1'b0;
`endif

    // Ready strobes and per-port read-data hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_ready <= 1'b0;
            dmem_ready <= 1'b0;
            i_sel      <= 1'b0;
            d_sel      <= 1'b0;
            imem_hold  <= '0;
            dmem_hold  <= '0;
        end else begin
            imem_ready <= enter_resp_c && (cur_port_c == PORT_I);
            dmem_ready <= enter_resp_c && (cur_port_c == PORT_D);
            i_sel      <= enter_resp_c && (cur_port_c == PORT_I) && !cur_err_c;
            d_sel      <= enter_resp_c && (cur_port_c == PORT_D) && !cur_we_c && !cur_err_c;
            if (i_sel)
                imem_hold <= ram_rdata;
            else if (enter_resp_c && (cur_port_c == PORT_I) && cur_err_c)
                imem_hold <= '0;
            if (d_sel)
                dmem_hold <= ram_rdata;
            else if (enter_resp_c && (cur_port_c == PORT_D) && !cur_we_c && cur_err_c)
                dmem_hold <= '0;
        end
    end

    // The RAM output register carries fresh read data during the response cycle
    assign imem_rdata = i_sel ? ram_rdata : imem_hold;
    assign dmem_rdata = d_sel ? ram_rdata : dmem_hold;

    rv_mem_array #(
        .DW    (DPWIDTH),
        .DEPTH (MEMWORDS)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (cur_we_c),
        .idx   (cur_idx_c),
        .wdata (cur_wdata_c),
        .rdata (ram_rdata)
    );

endmodule
